// File: rtl/lsic_gen2.sv
// lsic_gen2: level/edge interrupt controller with atomic claim and a
// bad-address FIFO, exposed as a bus slave at a fixed 64-word window.
module lsic_gen2 #(
  parameter int          NUM_IRQ   = 64,
  parameter logic [23:0] BASE_ADDR = 24'hf80300,
  parameter int          ERR_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irqs,
  input  logic [31:0]        badAddr,
  input  logic               badAddrValid,
  output logic               badAddrAck,
  output logic               cpu_irq,
  output logic               cpu_buserror,
  input  logic [4:0]         bus_burstcount,
  input  logic [31:0]        bus_writedata,
  input  logic [29:0]        bus_address,
  input  logic               bus_write,
  input  logic               bus_read,
  input  logic [3:0]         bus_byteenable,
  output logic               s_waitrequest,
  output logic [31:0]        s_readdata,
  output logic               s_readdatavalid,
  output logic               s_writeresponsevalid,
  output logic [1:0]         s_response
);

  localparam int W    = NUM_IRQ / 32;
  localparam int IPLW = $clog2(NUM_IRQ) + 1;
  localparam int PW   = $clog2(ERR_DEPTH);
  localparam int CW   = PW + 1;

  // Programmable state
  logic [NUM_IRQ-1:0] disa_r, pend_r, edge_r, irqs_q_r;
  logic [IPLW-1:0]    ipl_r;
  logic               claim_valid_r;
  logic [7:0]         claim_idx_r;

  // Bad-address FIFO
  logic [31:0]   fifo_r [ERR_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic          ack_r;

  // Bus response registers
  logic [31:0] readdata_r;
  logic        rdv_r, wrv_r;
  logic [1:0]  resp_r;

  // Address decode
  logic [5:0] off_s;
  logic [2:0] k_s;
  logic       k_ok_s, hit_s, is_rd_s, is_wr_s, legal_s;
  logic       sel_disa_s, sel_pend_s, sel_edge_s, sel_claim_s;
  logic       sel_ipl_s, sel_erraddr_s, sel_errstat_s;
  logic       wr_disa_s, wr_pend_s, wr_edge_s, wr_claim_s, wr_ipl_s, wr_errstat_s;
  logic       rd_claim_s, rd_pop_s;
  logic       full_s, push_ok_s;
  logic       unused_s;

  assign off_s         = bus_address[5:0];
  assign k_s           = off_s[2:0];
  assign k_ok_s        = ({29'd0, k_s} < 32'(W));
  assign hit_s         = (bus_address[29:6] == BASE_ADDR) && (bus_read || bus_write);
  // A request with both strobes set behaves as a read.
  assign is_rd_s       = hit_s && bus_read;
  assign is_wr_s       = hit_s && !bus_read;
  assign sel_disa_s    = (off_s[5:3] == 3'd0) && k_ok_s;
  assign sel_pend_s    = (off_s[5:3] == 3'd1) && k_ok_s;
  assign sel_edge_s    = (off_s[5:3] == 3'd2) && k_ok_s;
  assign sel_claim_s   = (off_s == 6'h18);
  assign sel_ipl_s     = (off_s == 6'h19);
  assign sel_erraddr_s = (off_s == 6'h1a);
  assign sel_errstat_s = (off_s == 6'h1b);
  assign legal_s       = (bus_burstcount == 5'd1) &&
                         (sel_disa_s || sel_pend_s || sel_edge_s || sel_claim_s ||
                          sel_ipl_s || sel_erraddr_s || sel_errstat_s);

  assign wr_disa_s    = is_wr_s && legal_s && sel_disa_s;
  assign wr_pend_s    = is_wr_s && legal_s && sel_pend_s;
  assign wr_edge_s    = is_wr_s && legal_s && sel_edge_s;
  assign wr_claim_s   = is_wr_s && legal_s && sel_claim_s;
  assign wr_ipl_s     = is_wr_s && legal_s && sel_ipl_s;
  assign wr_errstat_s = is_wr_s && legal_s && sel_errstat_s;
  assign rd_claim_s   = is_rd_s && legal_s && sel_claim_s && claim_valid_r;
  assign rd_pop_s     = is_rd_s && legal_s && sel_erraddr_s && (count_r != {CW{1'b0}});

  // Push is stored when there is room, including room freed by a same-cycle pop.
  assign full_s    = (count_r == CW'(ERR_DEPTH));
  assign push_ok_s = badAddrValid && (!full_s || rd_pop_s);

  assign unused_s = ^bus_byteenable;

  // Read data selection for the current request
  logic [31:0] rdata_s;
  always_comb begin
    rdata_s = 32'd0;
    for (int j = 0; j < W; j++) begin
      rdata_s = rdata_s |
                (((k_s == 3'(j)) && sel_disa_s) ? disa_r[j*32 +: 32] : 32'd0) |
                (((k_s == 3'(j)) && sel_pend_s) ? pend_r[j*32 +: 32] : 32'd0) |
                (((k_s == 3'(j)) && sel_edge_s) ? edge_r[j*32 +: 32] : 32'd0);
    end
    if (sel_claim_s) begin
      rdata_s = {claim_valid_r, 23'd0, claim_idx_r};
    end else if (sel_ipl_s) begin
      rdata_s = 32'(ipl_r);
    end else if (sel_erraddr_s) begin
      rdata_s = (count_r != {CW{1'b0}}) ? fifo_r[rd_ptr_r] : 32'd0;
    end else if (sel_errstat_s) begin
      rdata_s = {ovf_r, 15'd0, 16'(count_r)};
    end else begin
      rdata_s = rdata_s;
    end
  end

  // Eligibility mask and lowest-index priority resolution
  logic [NUM_IRQ-1:0] elig_s;
  logic               any_s;
  logic [7:0]         idx_s;
  always_comb begin
    elig_s = pend_r & ~disa_r;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig_s[i] = elig_s[i] && ((ipl_r == {IPLW{1'b0}}) || (i < int'(ipl_r)));
    end
    any_s = |elig_s;
    idx_s = 8'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx_s = elig_s[i] ? 8'(i) : idx_s;
    end
  end

  // Next pending vector: software writes, then hardware sets, then claim clear.
  // A hardware set overrides PEND/CLAIM writes; a claim read clears the claimed
  // line outright so a held level line re-pends on the following cycle.
  logic [NUM_IRQ-1:0] hw_set_s, pend_nx_s;
  always_comb begin
    hw_set_s  = irqs & ~(edge_r & irqs_q_r);
    pend_nx_s = pend_r;
    for (int j = 0; j < W; j++) begin
      pend_nx_s[j*32 +: 32] = (wr_pend_s && (k_s == 3'(j))) ?
                              ((bus_writedata == 32'd0) ? 32'd0 : (pend_r[j*32 +: 32] | bus_writedata)) :
                              pend_nx_s[j*32 +: 32];
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_nx_s[i] = (wr_claim_s && (bus_writedata[7:0] == 8'(i))) ? 1'b0 : pend_nx_s[i];
    end
    pend_nx_s = pend_nx_s | hw_set_s;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_nx_s[i] = (rd_claim_s && (claim_idx_r == 8'(i))) ? 1'b0 : pend_nx_s[i];
    end
  end

  // Interrupt state: configuration words, pending, input history and claim result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disa_r        <= {NUM_IRQ{1'b0}};
      edge_r        <= {NUM_IRQ{1'b0}};
      pend_r        <= {NUM_IRQ{1'b0}};
      irqs_q_r      <= {NUM_IRQ{1'b0}};
      ipl_r         <= {IPLW{1'b0}};
      claim_valid_r <= 1'b0;
      claim_idx_r   <= 8'd0;
    end else begin
      for (int j = 0; j < W; j++) begin
        if (wr_disa_s && (k_s == 3'(j))) disa_r[j*32 +: 32] <= bus_writedata;
        if (wr_edge_s && (k_s == 3'(j))) edge_r[j*32 +: 32] <= bus_writedata;
      end
      if (wr_ipl_s) ipl_r <= bus_writedata[IPLW-1:0];
      pend_r   <= pend_nx_s;
      irqs_q_r <= irqs;
      if (rd_claim_s) begin
        claim_valid_r <= 1'b0;
        claim_idx_r   <= 8'd0;
      end else begin
        claim_valid_r <= any_s;
        claim_idx_r   <= idx_s;
      end
    end
  end

  // Bad-address FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ERR_DEPTH; i++) fifo_r[i] <= 32'd0;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      ack_r <= badAddrValid;
      if (push_ok_s) begin
        fifo_r[wr_ptr_r] <= badAddr;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (rd_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, rd_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (badAddrValid && full_s && !rd_pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_errstat_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Registered bus response, one cycle after each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_r <= 32'd0;
      rdv_r      <= 1'b0;
      wrv_r      <= 1'b0;
      resp_r     <= 2'b00;
    end else begin
      rdv_r      <= is_rd_s;
      wrv_r      <= is_wr_s;
      resp_r     <= (hit_s && !legal_s) ? 2'b11 : 2'b00;
      readdata_r <= (is_rd_s && legal_s) ? rdata_s : 32'd0;
    end
  end

  assign badAddrAck           = ack_r;
  assign cpu_irq              = claim_valid_r;
  assign cpu_buserror         = (count_r != {CW{1'b0}});
  assign s_waitrequest        = 1'b0;
  assign s_readdata           = readdata_r;
  assign s_readdatavalid      = rdv_r;
  assign s_writeresponsevalid = wrv_r;
  assign s_response           = resp_r;

endmodule

// File: tb/tb_lsic_gen2.sv
// Directed and randomized bench for lsic_gen2 (64 lines, plus a 32-line
// instance for the out-of-range word check).
module tb_lsic_gen2;
  localparam logic [23:0] BASE = 24'hf80300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] irqs = 64'd0;
  logic [31:0] badAddr = 32'd0;
  logic        badAddrValid = 1'b0;
  logic [4:0]  bus_burstcount = 5'd1;
  logic [31:0] bus_writedata = 32'd0;
  logic [29:0] bus_address = 30'd0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [3:0]  bus_byteenable = 4'hf;

  logic        badAddrAck, cpu_irq, cpu_buserror, s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid, s_writeresponsevalid;
  logic [1:0]  s_response;

  logic        ack32, irq32, buserr32, wait32, rdv32, wrv32;
  logic [31:0] rdata32;
  logic [1:0]  resp32;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_pend [64];
  bit          m_disa [64];
  int          m_ipl;
  logic [31:0] q [$];
  bit          m_ovf;

  always #5 clk = ~clk;

  lsic_gen2 #(.NUM_IRQ(64), .BASE_ADDR(BASE), .ERR_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .irqs(irqs), .badAddr(badAddr), .badAddrValid(badAddrValid),
    .badAddrAck(badAddrAck), .cpu_irq(cpu_irq), .cpu_buserror(cpu_buserror),
    .bus_burstcount(bus_burstcount), .bus_writedata(bus_writedata), .bus_address(bus_address),
    .bus_write(bus_write), .bus_read(bus_read), .bus_byteenable(bus_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response));

  lsic_gen2 #(.NUM_IRQ(32), .BASE_ADDR(BASE), .ERR_DEPTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .irqs(irqs[31:0]), .badAddr(badAddr), .badAddrValid(badAddrValid),
    .badAddrAck(ack32), .cpu_irq(irq32), .cpu_buserror(buserr32),
    .bus_burstcount(bus_burstcount), .bus_writedata(bus_writedata), .bus_address(bus_address),
    .bus_write(bus_write), .bus_read(bus_read), .bus_byteenable(bus_byteenable),
    .s_waitrequest(wait32), .s_readdata(rdata32), .s_readdatavalid(rdv32),
    .s_writeresponsevalid(wrv32), .s_response(resp32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [5:0] off, input logic [4:0] bc,
                        output logic [31:0] data, output logic [1:0] resp);
    @(negedge clk);
    bus_address = {BASE, off}; bus_burstcount = bc; bus_read = 1'b1;
    @(posedge clk); #1;
    bus_read = 1'b0; bus_burstcount = 5'd1;
    chk("read strobes", {30'd0, s_writeresponsevalid, s_readdatavalid}, 32'h1);
    data = s_readdata; resp = s_response;
  endtask

  task automatic bus_wr(input logic [5:0] off, input logic [31:0] data,
                        input logic [4:0] bc, output logic [1:0] resp);
    @(negedge clk);
    bus_address = {BASE, off}; bus_burstcount = bc; bus_writedata = data; bus_write = 1'b1;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_burstcount = 5'd1;
    chk("write strobes", {30'd0, s_writeresponsevalid, s_readdatavalid}, 32'h2);
    resp = s_response;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    bus_rd(off, 5'd1, d, r);
    chk(tag, d, exp);
    chk({tag, " resp"}, {30'd0, r}, 32'h0);
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] data);
    logic [1:0] r;
    bus_wr(off, data, 5'd1, r);
    chk("write resp", {30'd0, r}, 32'h0);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Lowest eligible line according to pending/disable/IPL rules, -1 if none.
  function automatic int model_winner();
    for (int i = 0; i < 64; i++)
      if (m_pend[i] && !m_disa[i] && (m_ipl == 0 || i < m_ipl)) return i;
    return -1;
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          acks;

    // ---------------- reset ----------------
    irqs = '1; badAddrValid = 1'b1; bus_address = {BASE, 6'h18}; bus_read = 1'b1;
    ticks(3);
    chk("reset outs", {26'd0, cpu_irq, cpu_buserror, badAddrAck, s_readdatavalid,
                       s_writeresponsevalid, s_waitrequest}, 32'h0);
    chk("reset rdata", s_readdata, 32'h0);
    @(negedge clk);
    irqs = 64'd0; badAddrValid = 1'b0; bus_read = 1'b0; rst_n = 1'b1;
    ticks(1);
    chk("post-reset outs", {28'd0, cpu_irq, cpu_buserror, badAddrAck, s_response != 2'b00}, 32'h0);
    rd_chk("reset pend0", 6'h08, 32'h0);
    rd_chk("reset errstat", 6'h1b, 32'h0);

    // ---------------- level line 5 ----------------
    @(negedge clk); irqs[5] = 1'b1;
    ticks(1);
    chk("irq5 N+1", {31'd0, cpu_irq}, 32'h0);
    @(negedge clk); irqs[5] = 1'b0;
    ticks(1);
    chk("irq5 N+2", {31'd0, cpu_irq}, 32'h1);
    rd_chk("pend0 line5", 6'h08, 32'h20);
    rd_chk("claim line5", 6'h18, 32'h80000005);
    chk("irq after claim5", {31'd0, cpu_irq}, 32'h0);
    rd_chk("pend0 cleared", 6'h08, 32'h0);

    // ---------------- edge line 0 ----------------
    wr(6'h10, 32'h1);
    @(negedge clk); irqs[0] = 1'b1;
    ticks(10);
    rd_chk("edge pend0", 6'h08, 32'h1);
    rd_chk("edge claim", 6'h18, 32'h80000000);
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      chk("edge held no irq", {31'd0, cpu_irq}, 32'h0);
    end
    rd_chk("edge pend stays 0", 6'h08, 32'h0);
    @(negedge clk); irqs[0] = 1'b0;
    @(negedge clk); irqs[0] = 1'b1;
    ticks(1);
    chk("edge re-rise N+1", {31'd0, cpu_irq}, 32'h0);
    ticks(1);
    chk("edge re-rise N+2", {31'd0, cpu_irq}, 32'h1);
    @(negedge clk); irqs[0] = 1'b0;
    rd_chk("edge claim 2", 6'h18, 32'h80000000);
    wr(6'h10, 32'h0);

    // ---------------- IPL ----------------
    wr(6'h08, 32'h8);
    wr(6'h09, 32'h80000100);
    wr(6'h19, 32'd40);
    rd_chk("ipl readback", 6'h19, 32'd40);
    ticks(2);
    rd_chk("ipl claim 3", 6'h18, 32'h80000003);
    ticks(2);
    rd_chk("ipl masked", 6'h18, 32'h0);
    wr(6'h19, 32'h0);
    ticks(2);
    rd_chk("claim 40", 6'h18, 32'h80000028);
    ticks(2);
    rd_chk("claim 63", 6'h18, 32'h8000003f);
    ticks(2);
    chk("ipl all claimed", {31'd0, cpu_irq}, 32'h0);
    wr(6'h19, 32'hffffff85);
    rd_chk("ipl truncate", 6'h19, 32'h05);
    wr(6'h19, 32'h0);

    // ---------------- DISA1 ----------------
    wr(6'h01, 32'hffffffff);
    chk("dut32 disa1 resp", {30'd0, resp32}, 32'h3);
    @(negedge clk); irqs[33] = 1'b1;
    ticks(5);
    chk("disabled no irq", {31'd0, cpu_irq}, 32'h0);
    wr(6'h01, 32'h0);
    chk("disa clear +1", {31'd0, cpu_irq}, 32'h0);
    ticks(1);
    chk("disa clear +2", {31'd0, cpu_irq}, 32'h1);
    @(negedge clk); irqs[33] = 1'b0;
    rd_chk("claim 33", 6'h18, 32'h80000021);

    // ---------------- same-cycle set, illegal accesses ----------------
    @(negedge clk);
    irqs[1] = 1'b1; bus_address = {BASE, 6'h08}; bus_writedata = 32'h1; bus_write = 1'b1;
    @(posedge clk); #1;
    irqs[1] = 1'b0; bus_write = 1'b0;
    chk("pend wr resp", {29'd0, s_writeresponsevalid, s_response}, 32'h4);
    rd_chk("pend0 hw+sw", 6'h08, 32'h3);
    bus_wr(6'h08, 32'h0, 5'd2, r);
    chk("burst2 wr resp", {30'd0, r}, 32'h3);
    rd_chk("pend0 unchanged", 6'h08, 32'h3);
    bus_rd(6'h08, 5'd2, d, r);
    chk("burst2 rd data", d, 32'h0);
    chk("burst2 rd resp", {30'd0, r}, 32'h3);
    bus_rd(6'h1c, 5'd1, d, r);
    chk("unlisted resp", {30'd0, r}, 32'h3);
    @(negedge clk); bus_address = {24'h000123, 6'h08}; bus_read = 1'b1;
    ticks(1);
    bus_read = 1'b0;
    chk("outside window", {31'd0, s_readdatavalid}, 32'h0);
    wr(6'h08, 32'h0);

    // ---------------- bad-address FIFO directed ----------------
    acks = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); badAddrValid = 1'b1; badAddr = 32'(i);
      ticks(1);
      acks += int'(badAddrAck);
    end
    @(negedge clk); badAddrValid = 1'b0;
    ticks(1);
    chk("ack pulses", 32'(acks), 32'd5);
    chk("ack idle", {31'd0, badAddrAck}, 32'h0);
    chk("buserror set", {31'd0, cpu_buserror}, 32'h1);
    rd_chk("errstat full", 6'h1b, 32'h80000004);
    for (int i = 1; i <= 4; i++) begin
      rd_chk("pop", 6'h1a, 32'(i));
      chk("buserror during pops", {31'd0, cpu_buserror}, (i < 4) ? 32'h1 : 32'h0);
    end
    rd_chk("pop empty", 6'h1a, 32'h0);
    wr(6'h1b, 32'h0);
    rd_chk("errstat cleared", 6'h1b, 32'h0);

    // ---------------- bad-address FIFO random ----------------
    m_ovf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      bit push, pop;
      logic [31:0] a, exp_d;
      push = ($urandom_range(0, 1) == 1);
      pop  = ($urandom_range(0, 9) < 4);
      a    = $urandom;
      @(negedge clk);
      badAddrValid = push; badAddr = a;
      bus_address = {BASE, 6'h1a}; bus_read = pop;
      ticks(1);
      badAddrValid = 1'b0; bus_read = 1'b0;
      exp_d = 32'h0;
      if (pop && q.size() > 0) exp_d = q.pop_front();
      if (push) begin
        if (q.size() < 4) q.push_back(a);
        else m_ovf = 1'b1;
      end
      chk("rand ack", {31'd0, badAddrAck}, {31'd0, push});
      if (pop) chk("rand pop data", s_readdata, exp_d);
      chk("rand buserror", {31'd0, cpu_buserror}, {31'd0, q.size() != 0});
    end
    rd_chk("rand errstat", 6'h1b, {m_ovf, 15'd0, 16'(q.size())});

    // ---------------- claim arbitration random ----------------
    wr(6'h08, 32'h0); wr(6'h09, 32'h0);
    wr(6'h00, 32'h0); wr(6'h01, 32'h0);
    wr(6'h19, 32'h0);
    for (int i = 0; i < 64; i++) begin m_pend[i] = 1'b0; m_disa[i] = 1'b0; end
    m_ipl = 0;
    for (int it = 0; it < 12; it++) begin
      int w, win;
      logic [31:0] pd, dd, ip;
      w  = $urandom_range(0, 1);
      pd = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom);
      wr(6'(8 + w), pd);
      for (int b = 0; b < 32; b++) m_pend[w*32 + b] = (pd == 32'h0) ? 1'b0 : (m_pend[w*32 + b] | pd[b]);
      w  = $urandom_range(0, 1);
      dd = $urandom & $urandom;
      wr(6'(w), dd);
      for (int b = 0; b < 32; b++) m_disa[w*32 + b] = dd[b];
      ip = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(0, 200));
      wr(6'h19, ip);
      m_ipl = int'(ip) % 128;
      for (int c = 0; c < 2; c++) begin
        ticks(2);
        win = model_winner();
        chk("rand cpu_irq", {31'd0, cpu_irq}, (win >= 0) ? 32'h1 : 32'h0);
        rd_chk("rand claim", 6'h18, (win >= 0) ? (32'h80000000 | 32'(win)) : 32'h0);
        if (win >= 0) m_pend[win] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
